adsb_crc24: RTL and testbench
=============================

ADSB_CRC24 -- requirements
Module: adsb_crc24

Interface
REQ-001 SHALL have parameter POLY, default 24'hFFF409, the Mode S CRC-24 generator with x^24 implied.
REQ-002 SHALL have port clock, input, 1: system clock (20 MHz).
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port ena, input, 1: sample-rate enable; all state advances only when ena=1.
REQ-005 SHALL have port data_start, input, 1: preamble-detected pulse that begins a frame.
REQ-006 SHALL have port ena_out, input, 1: bit-valid strobe from the slicer.
REQ-007 SHALL have port data, input, 1: sliced bit, MSB first.
REQ-008 SHALL have port conf, input, 1: bit-confidence flag, valid with ena_out.
REQ-009 SHALL have port done, input, 1: end-of-frame pulse from the slicer.
REQ-010 SHALL have port crc_valid, output, 1: one-ena-cycle result strobe.
REQ-011 SHALL have port crc_ok, output, 1: syndrome==0 and length correct.
REQ-012 SHALL have port syndrome, output, 24: final remainder, held until the next crc_valid.
REQ-013 SHALL have port df, output, 5: downlink format taken from the first 5 bits.
REQ-014 SHALL have port long_frame, output, 1: df>=16, i.e. a 112-bit frame is expected.
REQ-015 SHALL have port low_conf, output, 7: count of bits with conf=0, saturating at 127.
REQ-016 SHALL have port len_err, output, 1: received bit count differs from the expected length; valid with crc_valid.

Function
REQ-017 SHALL implement the states IDLE, HDR, BODY and REPORT.
REQ-018 SHALL move IDLE->HDR on data_start&ena, clearing the remainder, bit count and low_conf.
REQ-019 SHALL, for each ena&ena_out bit, update the remainder as rem <= {rem[22:0],data} ^ (rem[23] ? POLY : 0) and increment the 7-bit bit count.
REQ-020 SHALL shift bits 0-4 into df during HDR and move HDR->BODY after the 5th bit, with long_frame set combinationally from df[4].
REQ-021 SHALL move BODY->REPORT when the bit count reaches the expected length (56/112) or on done, whichever comes first; bits arriving after that are ignored.
REQ-022 SHALL move REPORT->IDLE in the next ena cycle, asserting crc_valid for exactly that one ena cycle and registering syndrome, crc_ok and len_err.
REQ-023 SHALL set len_err=1 when done arrives with count != expected, or done arrives in HDR; crc_ok is then forced to 0.
REQ-024 SHALL treat a data_start in HDR/BODY as a retrigger that abandons the frame without crc_valid and restarts at HDR.
REQ-025 SHALL give precedence to data_start over ena_out when both occur in the same ena cycle, so the bit becomes bit 0 of the new frame.
REQ-026 SHALL hold the bit count at 127 with no wrap if done never arrives, and SHALL reach REPORT via REQ-021 at the expected length.
REQ-027 SHALL ignore done and ena_out in IDLE.
REQ-028 SHALL have a latency of 1 ena cycle from the last bit (or done) to crc_valid.

Reset
REQ-029 SHALL, on reset, set state IDLE, remainder 0, count 0, and crc_valid, crc_ok, syndrome, df, low_conf and len_err to 0, regardless of ena.
REQ-030 SHALL abandon a frame in progress when reset is asserted, with no crc_valid produced.

Structure
REQ-031 SHALL place POLY, the lengths 56/112, DF_LONG_MIN=16 and the state encoding in a shared adsb_pkg.
REQ-032 SHALL contain one sub-module, crc24_step, the combinational single-bit remainder update.
REQ-033 SHALL be registered only on clock, with no latches and no multicycle paths.

Verification
REQ-034 SHALL cover: 112 bits of 8D4840D6202CC371C32CE0576098, conf=1, then done -> crc_valid=1, crc_ok=1, syndrome=0, df=17, long_frame=1, len_err=0.
REQ-035 SHALL cover: the same frame with bit 40 inverted -> crc_ok=0, syndrome nonzero.
REQ-036 SHALL cover: a DF11 56-bit frame with its valid parity -> crc_ok=1, long_frame=0; done after 50 bits -> len_err=1, crc_ok=0.
REQ-037 SHALL cover: data_start at bit 30, then a valid 112-bit frame -> exactly one crc_valid, with crc_ok=1.
REQ-038 SHALL cover: 10 bits with conf=0 inside a valid frame -> low_conf=10, crc_ok=1; reset at bit 60 -> no crc_valid, all outputs 0.
REQ-039 SHALL cover: ena held low for 3 of every 4 clocks -> results identical to the ena=1 runs.

Source files
------------

// File: rtl/adsb_pkg.sv
// Shared constants and state encoding for the Mode S CRC-24 frame checker.
package adsb_pkg;

    localparam logic [23:0] CRC24_POLY  = 24'hFFF409;
    localparam logic [6:0]  LEN_SHORT   = 7'd56;
    localparam logic [6:0]  LEN_LONG    = 7'd112;
    localparam logic [4:0]  DF_LONG_MIN = 5'd16;
    localparam logic [6:0]  HDR_BITS    = 7'd5;
    localparam logic [6:0]  COUNT_MAX   = 7'd127;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HDR    = 2'd1,
        ST_BODY   = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    function automatic logic [6:0] frame_len(input logic [4:0] df_val);
        return (df_val >= DF_LONG_MIN) ? LEN_LONG : LEN_SHORT;
    endfunction

    function automatic logic [6:0] sat_inc7(input logic [6:0] v);
        return (v == COUNT_MAX) ? v : v + 7'd1;
    endfunction

endpackage

// File: rtl/adsb_crc24_step.sv
// Single-bit Mode S CRC-24 remainder update (x^24 implied in POLY).
module crc24_step
    import adsb_pkg::*;
#(
    parameter logic [23:0] POLY = CRC24_POLY
) (
    input  logic [23:0] rem,
    input  logic        data,
    output logic [23:0] rem_next
);

    always_comb begin
        rem_next = {rem[22:0], data} ^ (rem[23] ? POLY : '0);
    end

endmodule

// File: rtl/adsb_crc24.sv
// Mode S frame checker: tracks DF/length, accumulates CRC-24 remainder per sliced bit
// and reports syndrome, length error and low-confidence count once per frame.
module adsb_crc24
    import adsb_pkg::*;
#(
    parameter logic [23:0] POLY = CRC24_POLY
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ena,
    input  logic        data_start,
    input  logic        ena_out,
    input  logic        data,
    input  logic        conf,
    input  logic        done,
    output logic        crc_valid,
    output logic        crc_ok,
    output logic [23:0] syndrome,
    output logic [4:0]  df,
    output logic        long_frame,
    output logic [6:0]  low_conf,
    output logic        len_err
);

    state_t      state;
    state_t      state_next;
    logic [23:0] rem;
    logic [6:0]  count;
    logic        start;
    logic        take;
    logic        fire;
    logic [6:0]  exp_len;

    logic [23:0] rem_base;
    logic [23:0] rem_step;
    logic [23:0] rem_next;
    logic [6:0]  count_base;
    logic [6:0]  count_next;
    logic [4:0]  df_base;
    logic [4:0]  df_next;
    logic [6:0]  lc_base;
    logic [6:0]  lc_next;

    always_comb begin
        exp_len    = frame_len(df);
        long_frame = (df >= DF_LONG_MIN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    // A data_start always wins; a coincident bit becomes bit 0 of the new frame.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        take       = 1'b0;
        fire       = 1'b0;
        if (ena) begin
            unique case (state)
                ST_IDLE: begin
                    if (data_start) begin
                        start      = 1'b1;
                        take       = ena_out;
                        state_next = ST_HDR;
                    end
                end
                ST_HDR, ST_BODY: begin
                    if (data_start) begin
                        start      = 1'b1;
                        take       = ena_out;
                        state_next = ST_HDR;
                    end else begin
                        take = ena_out;
                        if (done) begin
                            state_next = ST_REPORT;
                        end else if (ena_out && (state == ST_HDR)
                                     && (sat_inc7(count) == HDR_BITS)) begin
                            state_next = ST_BODY;
                        end else if (ena_out && (state == ST_BODY)
                                     && (sat_inc7(count) == exp_len)) begin
                            state_next = ST_REPORT;
                        end
                    end
                end
                ST_REPORT: begin
                    fire       = 1'b1;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    crc24_step #(.POLY(POLY)) u_step (
        .rem      (rem_base),
        .data     (data),
        .rem_next (rem_step)
    );

    always_comb begin
        rem_base   = start ? '0 : rem;
        count_base = start ? '0 : count;
        df_base    = start ? '0 : df;
        lc_base    = start ? '0 : low_conf;
        rem_next   = take ? rem_step : rem_base;
        count_next = take ? sat_inc7(count_base) : count_base;
        df_next    = (take && (start || (state == ST_HDR))) ? {df_base[3:0], data} : df_base;
        lc_next    = (take && !conf) ? sat_inc7(lc_base) : lc_base;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem       <= '0;
            count     <= '0;
            df        <= '0;
            low_conf  <= '0;
            crc_valid <= 1'b0;
            crc_ok    <= 1'b0;
            syndrome  <= '0;
            len_err   <= 1'b0;
        end else if (ena) begin
            rem       <= rem_next;
            count     <= count_next;
            df        <= df_next;
            low_conf  <= lc_next;
            crc_valid <= fire;
            if (fire) begin
                syndrome <= rem;
                len_err  <= (count != exp_len);
                crc_ok   <= (rem == '0) && (count == exp_len);
            end
        end
    end

endmodule

// File: tb/tb_adsb_crc24.sv
// Randomised scoreboard bench for adsb_crc24 against a polynomial long-division model.
module tb_adsb_crc24;

    localparam logic [24:0] GEN = 25'h1FFF409;

    logic        clock = 1'b0;
    logic        reset;
    logic        ena;
    logic        data_start;
    logic        ena_out;
    logic        data;
    logic        conf;
    logic        done;
    logic        crc_valid;
    logic        crc_ok;
    logic [23:0] syndrome;
    logic [4:0]  df;
    logic        long_frame;
    logic [6:0]  low_conf;
    logic        len_err;

    typedef struct {
        logic [23:0] syn;
        logic        ok;
        logic [4:0]  df;
        logic        lf;
        logic        le;
        logic [6:0]  lc;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int   checks = 0;
    int   errors = 0;
    bit   sparse = 1'b0;
    bit   prev_valid = 1'b0;
    bit   fbits[128];
    bit   fconf[128];

    adsb_crc24 #(.POLY(24'hFFF409)) dut (
        .clock      (clock),
        .reset      (reset),
        .ena        (ena),
        .data_start (data_start),
        .ena_out    (ena_out),
        .data       (data),
        .conf       (conf),
        .done       (done),
        .crc_valid  (crc_valid),
        .crc_ok     (crc_ok),
        .syndrome   (syndrome),
        .df         (df),
        .long_frame (long_frame),
        .low_conf   (low_conf),
        .len_err    (len_err)
    );

    always #25 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Remainder of the first n bits (as a polynomial, MSB first) modulo the generator.
    function automatic logic [23:0] mod_g(input int n);
        bit          a[128];
        logic [24:0] g;
        logic [23:0] r;
        g = GEN;
        r = '0;
        for (int i = 0; i < n; i++) a[i] = fbits[i];
        for (int i = 0; i + 24 < n; i++) begin
            if (a[i]) begin
                for (int j = 0; j < 25; j++) a[i+j] = a[i+j] ^ g[24-j];
            end
        end
        for (int i = (n > 24) ? n - 24 : 0; i < n; i++) r = {r[22:0], a[i]};
        return r;
    endfunction

    task automatic set_parity(input int n);
        logic [23:0] r;
        for (int k = n - 24; k < n; k++) fbits[k] = 1'b0;
        r = mod_g(n);
        for (int k = 0; k < 24; k++) fbits[n-24+k] = r[23-k];
    endtask

    function automatic exp_t predict(input int n);
        exp_t       e;
        int         cnt;
        int         explen;
        int         hdr;
        int         lc;
        logic [4:0] d;
        d   = '0;
        hdr = (n < 5) ? n : 5;
        for (int i = 0; i < hdr; i++) d = {d[3:0], fbits[i]};
        explen = (d >= 5'd16) ? 112 : 56;
        cnt    = (n < explen) ? n : explen;
        lc     = 0;
        for (int i = 0; i < cnt; i++) if (!fconf[i]) lc++;
        e.syn = mod_g(cnt);
        e.df  = d;
        e.lf  = (d >= 5'd16);
        e.le  = (cnt != explen);
        e.lc  = 7'(lc);
        e.ok  = (e.syn == 24'd0) && !e.le;
        return e;
    endfunction

    // One ena cycle of slicer activity; in sparse mode three gated clocks of noise precede it.
    task automatic tick(input bit ds, input bit eo, input bit d, input bit c, input bit dn);
        if (sparse) begin
            repeat (3) begin
                ena        = 1'b0;
                data_start = 1'($urandom);
                ena_out    = 1'($urandom);
                data       = 1'($urandom);
                conf       = 1'($urandom);
                done       = 1'($urandom);
                @(posedge clock); #1;
            end
        end
        ena        = 1'b1;
        data_start = ds;
        ena_out    = eo;
        data       = d;
        conf       = c;
        done       = dn;
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic run_frame(input int n, input bit send_done);
        int i0;
        sb.push_back(predict(n));
        i0 = 0;
        if (1'($urandom)) begin
            tick(1'b1, 1'b1, fbits[0], fconf[0], 1'b0);
            i0 = 1;
        end else begin
            tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        for (int i = i0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            tick(1'b0, 1'b1, fbits[i], fconf[i], 1'b0);
        end
        if (send_done) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
    endtask

    task automatic partial(input int n);
        tick(1'b1, 1'b1, fbits[0], fconf[0], 1'b0);
        for (int i = 1; i < n; i++) tick(1'b0, 1'b1, fbits[i], fconf[i], 1'b0);
    endtask

    task automatic rand_bits();
        for (int i = 0; i < 128; i++) begin
            fbits[i] = 1'($urandom);
            fconf[i] = 1'b1;
        end
    endtask

    task automatic set_df(input logic [4:0] d);
        for (int i = 0; i < 5; i++) fbits[i] = d[4-i];
    endtask

    task automatic load_f1();
        logic [111:0] v;
        v = 112'h8D4840D6202CC371C32CE0576098;
        for (int i = 0; i < 112; i++) begin
            fbits[i] = v[111-i];
            fconf[i] = 1'b1;
        end
    endtask

    task automatic reset_mid();
        ena   = 1'($urandom);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        ena   = 1'b0;
        chk("rst_crc_valid", 32'(crc_valid), 32'd0);
        chk("rst_crc_ok", 32'(crc_ok), 32'd0);
        chk("rst_syndrome", 32'(syndrome), 32'd0);
        chk("rst_df", 32'(df), 32'd0);
        chk("rst_long_frame", 32'(long_frame), 32'd0);
        chk("rst_low_conf", 32'(low_conf), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
    endtask

    task automatic run_suite();
        int         n;
        int         explen;
        int         mode;
        logic [4:0] d;
        load_f1();
        run_frame(112, 1'b1);
        load_f1();
        fbits[40] = ~fbits[40];
        run_frame(112, 1'b1);
        rand_bits();
        set_df(5'd11);
        set_parity(56);
        run_frame(56, 1'b1);
        run_frame(50, 1'b1);
        rand_bits();
        partial(30);
        load_f1();
        run_frame(112, 1'b1);
        rand_bits();
        set_df(5'd17);
        set_parity(112);
        for (int k = 0; k < 10; k++) fconf[7 + k * 10] = 1'b0;
        run_frame(112, 1'b1);
        rand_bits();
        fbits[0] = 1'b1;
        partial(60);
        reset_mid();
        idle(2);
        rand_bits();
        run_frame(3, 1'b1);
        for (int r = 0; r < 12; r++) begin
            d = 5'($urandom);
            explen = (d >= 5'd16) ? 112 : 56;
            rand_bits();
            for (int i = 0; i < 128; i++) fconf[i] = ($urandom_range(0, 7) != 0);
            set_df(d);
            set_parity(explen);
            mode = $urandom_range(0, 3);
            n = explen;
            if (mode == 1) begin
                n = $urandom_range(5, explen - 1);
                fbits[n] = ~fbits[n];
                n = explen;
            end else if (mode == 2) begin
                n = $urandom_range(1, explen - 1);
            end else if (mode == 3) begin
                n = explen + $urandom_range(1, 8);
            end
            run_frame(n, (mode == 2) ? 1'b1 : 1'($urandom));
        end
    endtask

    always @(negedge clock) begin
        if (crc_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_crc_valid: got 1 expected 0");
            end else begin
                got_e = sb.pop_front();
                chk("syndrome", 32'(syndrome), 32'(got_e.syn));
                chk("crc_ok", 32'(crc_ok), 32'(got_e.ok));
                chk("df", 32'(df), 32'(got_e.df));
                chk("long_frame", 32'(long_frame), 32'(got_e.lf));
                chk("len_err", 32'(len_err), 32'(got_e.le));
                chk("low_conf", 32'(low_conf), 32'(got_e.lc));
            end
        end
        prev_valid = crc_valid;
    end

    initial begin
        reset      = 1'b1;
        ena        = 1'b0;
        data_start = 1'b0;
        ena_out    = 1'b0;
        data       = 1'b0;
        conf       = 1'b0;
        done       = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("init_crc_valid", 32'(crc_valid), 32'd0);
        chk("init_crc_ok", 32'(crc_ok), 32'd0);
        chk("init_syndrome", 32'(syndrome), 32'd0);
        chk("init_df", 32'(df), 32'd0);
        chk("init_long_frame", 32'(long_frame), 32'd0);
        chk("init_low_conf", 32'(low_conf), 32'd0);
        chk("init_len_err", 32'(len_err), 32'd0);
        reset = 1'b0;
        sparse = 1'b0;
        run_suite();
        sparse = 1'b1;
        run_suite();
        idle(8);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
